skew_response_checker: RTL and testbench
========================================

SKEW_RESPONSE_CHECKER -- requirements
Module: skew_response_checker

Interface
REQ-001 Parameter WIDTH, default 8, width of driven and sampled words.
REQ-002 Parameter LATENCY, default 3, cycles from a word being driven to its response being sampled; legal range 1..16.
REQ-003 Parameter INVERT, default 1: expected response is ~d when 1, d when 0.
REQ-004 Parameter CNT_W, default 8, width of the pass and error counters.
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle pulse that begins a checking run.
REQ-008 stop  input  1  single-cycle pulse that ends stimulus acceptance and begins draining.
REQ-009 d_valid  input  1  qualifies d this cycle.
REQ-010 d  input  WIDTH  word driven toward the DUT this cycle.
REQ-011 q  input  WIDTH  DUT response as sampled this cycle.
REQ-012 busy  output  1  high in states RUN and DRAIN.
REQ-013 done  output  1  high in state DONE.
REQ-014 pass_cnt  output  CNT_W  number of matching comparisons.
REQ-015 err_cnt  output  CNT_W  number of mismatching comparisons.
REQ-016 err  output  1  sticky flag, set on the first mismatch of a run.
REQ-017 first_exp  output  WIDTH  expected value at the first mismatch.
REQ-018 first_got  output  WIDTH  sampled q at the first mismatch.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE->RUN on start; DONE->RUN on start; RUN->DRAIN on stop; DRAIN->DONE in the cycle in which the expectation pipeline holds no valid entry; no other transitions.
REQ-021 start in RUN or DRAIN SHALL be ignored; stop outside RUN SHALL be ignored; start and stop together in IDLE/DONE SHALL enter RUN, with stop ignored.
REQ-022 Entering RUN SHALL clear pass_cnt, err_cnt, err, first_exp, first_got and every pipeline valid bit.
REQ-023 The expectation pipeline SHALL be LATENCY stages of {valid, expected}; stage 0 loads {d_valid & (state==RUN), INVERT ? ~d : d}; each stage shifts one stage per cycle.
REQ-024 d_valid in the cycle stop is accepted SHALL still be loaded; d_valid in DRAIN, DONE or IDLE SHALL load valid=0.
REQ-025 A word loaded at edge N SHALL be compared against q at edge N+LATENCY, i.e. when it occupies the last stage.
REQ-026 A comparison SHALL occur only when the last stage is valid, in RUN or DRAIN; no other cycle changes a counter.
REQ-027 q == expected SHALL increment pass_cnt; otherwise it SHALL increment err_cnt.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-029 On a mismatch while err==0: set err; load first_exp and first_got. Later mismatches SHALL leave first_exp/first_got unchanged.
REQ-030 Counters, err and captured values SHALL hold in DONE until the next start or reset.
REQ-031 Back-to-back d_valid SHALL be accepted every cycle with no stall; there is no backpressure.

Reset
REQ-032 rst_n low SHALL force, asynchronously: state IDLE, all pipeline valid bits 0, pass_cnt=0, err_cnt=0, err=0, first_exp=0, first_got=0, busy=0, done=0.
REQ-033 Reset asserted mid-run SHALL discard all in-flight expectations; after release, no comparison occurs until a new start and LATENCY cycles of accepted stimulus.

Verification
REQ-034 WIDTH=8, LATENCY=3, INVERT=1; DUT model is a 3-cycle delay of ~d. start, then d_valid with d=1<<i for i=0..7 on consecutive cycles, then stop -> after drain: pass_cnt=8, err_cnt=0, err=0, done=1.
REQ-035 Same setup, but the model's 5th response forced to 8'h00 (expected 8'hEF) -> err_cnt=1, pass_cnt=7, err=1, first_exp=8'hEF, first_got=8'h00.
REQ-036 Model delay set to 2 cycles with d=8'h01,8'h02,8'h04 -> all three mismatch; err_cnt=3; first_exp=8'hFE.
REQ-037 CNT_W=2, 6 matching words -> pass_cnt saturates at 3.
REQ-038 rst_n pulsed low 1 cycle after the 2nd d_valid of a run -> all outputs zero immediately, state IDLE; the following 3 cycles of q toggling cause no count change.
REQ-039 start+stop in the same IDLE cycle, then d_valid 8'hAA for 2 cycles and stop -> both accepted, pass_cnt=2 with a correct model; start during DRAIN has no effect.

Source files
------------

// File: rtl/skew_response_checker.sv
// Response checker: predicts each driven word's response LATENCY cycles ahead
// and scores the sampled q against it, capturing the first mismatch of a run.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_RUN   | accepting stimulus and comparing responses
// ST_DRAIN | stimulus closed, comparing the words still in flight
// ST_DONE  | pipeline empty, results held until the next start

module skew_response_checker #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int INVERT  = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t             state;
    logic [LATENCY-1:0] pipe_v;
    logic [WIDTH-1:0]   pipe_e [LATENCY];

    logic             load_v;
    logic [WIDTH-1:0] load_e;
    logic [WIDTH-1:0] exp_last;
    logic             cmp_en;
    logic             hit;

    assign load_v   = d_valid && (state == ST_RUN);
    assign load_e   = (INVERT != 0) ? ~d : d;
    assign exp_last = pipe_e[LATENCY-1];
    assign cmp_en   = pipe_v[LATENCY-1] && ((state == ST_RUN) || (state == ST_DRAIN));
    assign hit      = (q == exp_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pipe_v    <= '0;
            for (int i = 0; i < LATENCY; i++) pipe_e[i] <= '0;
            pass_cnt  <= '0;
            err_cnt   <= '0;
            err       <= 1'b0;
            first_exp <= '0;
            first_got <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_e[i] <= pipe_e[i-1];
            end
            pipe_v[0] <= load_v;
            pipe_e[0] <= load_e;

            if (cmp_en) begin
                if (hit) begin
                    if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                    if (!err) begin
                        err       <= 1'b1;
                        first_exp <= exp_last;
                        first_got <= q;
                    end
                end
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    // a simultaneous stop is dropped: the run only closes from RUN
                    if (start) begin
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pipe_v    <= '0;
                        pass_cnt  <= '0;
                        err_cnt   <= '0;
                        err       <= 1'b0;
                        first_exp <= '0;
                        first_got <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pipe_v == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skew_response_checker.sv
// Directed bench: a delay-line model of the target DUT feeds q; one checker at
// default widths and a second with 2-bit counters share the same stimulus.

module tb_skew_response_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       d_valid = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q;

    logic       busy, done, err;
    logic [7:0] pass_cnt, err_cnt, first_exp, first_got;
    logic       busy2, done2, err2;
    logic [1:0] pass_cnt2, err_cnt2;
    logic [7:0] first_exp2, first_got2;

    int checks = 0;
    int failures = 0;

    // model of the DUT under test: response is ~d delayed by mdelay cycles
    logic [7:0] hist [4];
    int         mdelay = 3;
    logic       corrupt_en = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        hist[0] <= d;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end

    assign q = (corrupt_en && hist[mdelay-1] == 8'h10) ? 8'h00 : ~hist[mdelay-1];

    skew_response_checker #(.WIDTH(8), .LATENCY(3), .INVERT(1), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .d_valid(d_valid),
        .d(d), .q(q), .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .err_cnt(err_cnt), .err(err), .first_exp(first_exp), .first_got(first_got)
    );

    skew_response_checker #(.WIDTH(8), .LATENCY(3), .INVERT(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .d_valid(d_valid),
        .d(d), .q(q), .busy(busy2), .done(done2), .pass_cnt(pass_cnt2),
        .err_cnt(err_cnt2), .err(err2), .first_exp(first_exp2), .first_got(first_got2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        d_valid = 1'b1;
        d = w;
        tick();
        d_valid = 1'b0;
        d = 8'h00;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        repeat (5) tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_pass", pass_cnt, 8'd0);
        check_eq("rst_errc", err_cnt, 8'd0);
        check_eq("rst_err", err, 1'b0);
        rst_n = 1'b1;
        tick();

        // clean run, one-hot words
        pulse_start();
        check_eq("t1_busy", busy, 1'b1);
        for (int i = 0; i < 8; i++) send_word(8'h01 << i);
        pulse_stop();
        wait_done("t1");
        check_eq("t1_pass", pass_cnt, 8'd8);
        check_eq("t1_errc", err_cnt, 8'd0);
        check_eq("t1_err", err, 1'b0);
        check_eq("t1_sat_pass", pass_cnt2, 2'd3);

        // fifth response corrupted; restart from DONE must clear counts
        corrupt_en = 1'b1;
        pulse_start();
        check_eq("t2_clr_pass", pass_cnt, 8'd0);
        for (int i = 0; i < 8; i++) send_word(8'h01 << i);
        pulse_stop();
        wait_done("t2");
        corrupt_en = 1'b0;
        check_eq("t2_pass", pass_cnt, 8'd7);
        check_eq("t2_errc", err_cnt, 8'd1);
        check_eq("t2_err", err, 1'b1);
        check_eq("t2_fexp", first_exp, 8'hEF);
        check_eq("t2_fgot", first_got, 8'h00);
        check_eq("t2_sat_errc", err_cnt2, 2'd1);

        // model one cycle short: every response belongs to the next word
        mdelay = 2;
        pulse_start();
        send_word(8'h01);
        send_word(8'h02);
        send_word(8'h04);
        pulse_stop();
        wait_done("t3");
        check_eq("t3_pass", pass_cnt, 8'd0);
        check_eq("t3_errc", err_cnt, 8'd3);
        check_eq("t3_fexp", first_exp, 8'hFE);
        check_eq("t3_fgot", first_got, 8'hFD);
        check_eq("t3_sat_errc", err_cnt2, 2'd3);
        mdelay = 3;

        // start clears the previous failure capture
        pulse_start();
        check_eq("t4_clr_errc", err_cnt, 8'd0);
        check_eq("t4_clr_err", err, 1'b0);
        check_eq("t4_clr_fexp", first_exp, 8'h00);
        send_word(8'h11);
        send_word(8'h22);
        rst_n = 1'b0;
        #1;
        check_eq("t4_rst_busy", busy, 1'b0);
        check_eq("t4_rst_done", done, 1'b0);
        check_eq("t4_rst_pass", pass_cnt, 8'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = (i % 2 == 0) ? 8'h5A : 8'hA5;
            tick();
        end
        d = 8'h00;
        check_eq("t4_post_pass", pass_cnt, 8'd0);
        check_eq("t4_post_errc", err_cnt, 8'd0);
        check_eq("t4_post_busy", busy, 1'b0);

        // start+stop together in IDLE, then a start during DRAIN
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check_eq("t5_busy", busy, 1'b1);
        send_word(8'hAA);
        send_word(8'hAA);
        pulse_stop();
        pulse_start();
        check_eq("t5_drain_busy", busy, 1'b1);
        wait_done("t5");
        check_eq("t5_pass", pass_cnt, 8'd2);
        check_eq("t5_errc", err_cnt, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
